float_to_int: RTL and testbench

- Pipelined converter from IEEE-754 single-precision to a 32-bit two's-complement integer.
- Reverse direction of the team's combinational integer-to-float block; used on datapath return paths that must hand float results back to integer logic.
- Fixed 3-stage pipeline with valid/ready handshakes on both sides, full-rate throughput, backpressure, saturation and exception flags.

---
 rtl/float_to_int.sv | 208 ++++++++++++++++++++
 tb/tb_float_to_int.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/float_to_int.sv
// Three-stage IEEE-754 single-precision to 32-bit two's-complement converter
// with valid/ready handshakes, saturation and invalid/inexact flags.
module float_to_int #(
    parameter int ROUND_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] float_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] int_out,
    output logic        invalid,
    output logic        inexact
);

    typedef enum logic [2:0] {
        CLS_ZERO,
        CLS_DENORM,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } cls_t;

    // Handshake: a beat moves when valid && ready on that side. The whole
    // pipeline advances unless the output holds an unaccepted result, so
    // in_ready = !(out_valid && !out_ready) and it never depends on in_valid.
    logic stall;
    logic advance;

    // Stage 1: unpacked operand
    logic        s1_valid_q, s1_valid_d;
    logic        s1_sign_q, s1_sign_d;
    logic [7:0]  s1_exp_q, s1_exp_d;
    logic [23:0] s1_man_q, s1_man_d;
    cls_t        s1_cls_q, s1_cls_d;

    // Stage 2: aligned magnitude with guard/sticky
    logic        s2_valid_q, s2_valid_d;
    logic        s2_sign_q, s2_sign_d;
    logic [31:0] s2_mag_q, s2_mag_d;
    logic        s2_guard_q, s2_guard_d;
    logic        s2_sticky_q, s2_sticky_d;
    logic        s2_nan_q, s2_nan_d;
    logic        s2_ovf_q, s2_ovf_d;

    // Stage 3: final result
    logic        out_valid_q, out_valid_d;
    logic [31:0] int_out_q, int_out_d;
    logic        invalid_q, invalid_d;
    logic        inexact_q, inexact_d;

    logic [7:0]  s2_rshift;
    logic [7:0]  s2_lshift;
    logic [47:0] s2_wide;
    logic        round_up;
    logic [31:0] rounded;

    assign stall    = out_valid_q && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_man_d   = s1_man_q;
        s1_cls_d   = s1_cls_q;
        if (advance) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_sign_d = float_in[31];
                s1_exp_d  = float_in[30:23];
                s1_man_d  = {(float_in[30:23] != 8'd0), float_in[22:0]};
                if (float_in[30:23] == 8'd0) begin
                    s1_cls_d = (float_in[22:0] == 23'd0) ? CLS_ZERO : CLS_DENORM;
                end else if (float_in[30:23] == 8'hFF) begin
                    s1_cls_d = (float_in[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
                end else begin
                    s1_cls_d = CLS_NORMAL;
                end
            end
        end
    end

    // Exponent field 150 means E = 23: the mantissa already sits at bit 0.
    assign s2_rshift = 8'd150 - s1_exp_q;
    assign s2_lshift = s1_exp_q - 8'd150;
    assign s2_wide   = {s1_man_q, 24'd0} >> s2_rshift;

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_sign_d   = s2_sign_q;
        s2_mag_d    = s2_mag_q;
        s2_guard_d  = s2_guard_q;
        s2_sticky_d = s2_sticky_q;
        s2_nan_d    = s2_nan_q;
        s2_ovf_d    = s2_ovf_q;
        if (advance) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sign_d   = s1_sign_q;
                s2_mag_d    = 32'd0;
                s2_guard_d  = 1'b0;
                s2_sticky_d = 1'b0;
                s2_nan_d    = 1'b0;
                s2_ovf_d    = 1'b0;
                case (s1_cls_q)
                    CLS_ZERO, CLS_DENORM: s2_sticky_d = (s1_cls_q == CLS_DENORM);
                    CLS_INF:              s2_ovf_d    = 1'b1;
                    CLS_NAN:              s2_nan_d    = 1'b1;
                    default: begin
                        if (s1_exp_q >= 8'd158) begin
                            // Only -2^31 exactly is representable at E = 31.
                            s2_ovf_d = !(s1_sign_q && s1_exp_q == 8'd158 &&
                                         s1_man_q[22:0] == 23'd0);
                            s2_mag_d = 32'h8000_0000;
                        end else if (s1_exp_q >= 8'd151) begin
                            s2_mag_d = {8'd0, s1_man_q} << s2_lshift;
                        end else if (s1_exp_q >= 8'd127) begin
                            s2_mag_d    = {8'd0, s2_wide[47:24]};
                            s2_guard_d  = s2_wide[23];
                            s2_sticky_d = |s2_wide[22:0];
                        end else if (s1_exp_q == 8'd126) begin
                            s2_guard_d  = s1_man_q[23];
                            s2_sticky_d = |s1_man_q[22:0];
                        end else begin
                            s2_sticky_d = |s1_man_q;
                        end
                    end
                endcase
            end
        end
    end

    assign round_up = (ROUND_MODE == 1) && s2_guard_q && (s2_sticky_q || s2_mag_q[0]);
    assign rounded  = s2_mag_q + {31'd0, round_up};

    always_comb begin
        out_valid_d = out_valid_q;
        int_out_d   = int_out_q;
        invalid_d   = invalid_q;
        inexact_d   = inexact_q;
        if (advance) begin
            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                if (s2_nan_q) begin
                    int_out_d = 32'h8000_0000;
                    invalid_d = 1'b1;
                    inexact_d = 1'b0;
                end else if (s2_ovf_q) begin
                    int_out_d = s2_sign_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    invalid_d = 1'b1;
                    inexact_d = 1'b0;
                end else begin
                    int_out_d = s2_sign_q ? (~rounded + 32'd1) : rounded;
                    invalid_d = 1'b0;
                    inexact_d = s2_guard_q || s2_sticky_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 8'd0;
            s1_man_q    <= 24'd0;
            s1_cls_q    <= CLS_ZERO;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_mag_q    <= 32'd0;
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_nan_q    <= 1'b0;
            s2_ovf_q    <= 1'b0;
            out_valid_q <= 1'b0;
            int_out_q   <= 32'd0;
            invalid_q   <= 1'b0;
            inexact_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_man_q    <= s1_man_d;
            s1_cls_q    <= s1_cls_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_mag_q    <= s2_mag_d;
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
            s2_nan_q    <= s2_nan_d;
            s2_ovf_q    <= s2_ovf_d;
            out_valid_q <= out_valid_d;
            int_out_q   <= int_out_d;
            invalid_q   <= invalid_d;
            inexact_q   <= inexact_d;
        end
    end

    assign out_valid = out_valid_q;
    assign int_out   = int_out_q;
    assign invalid   = invalid_q;
    assign inexact   = inexact_q;

endmodule

// File: tb/tb_float_to_int.sv
// Scoreboard bench for float_to_int: truncating and round-to-nearest instances
// share one stimulus stream; a monitor pops expected results per instance.
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] float_in = 32'd0;
    logic        out_ready = 1'b1;

    logic        in_ready0, out_valid0, invalid0, inexact0;
    logic [31:0] int_out0;
    logic        in_ready1, out_valid1, invalid1, inexact1;
    logic [31:0] int_out1;

    float_to_int #(.ROUND_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .float_in(float_in), .out_valid(out_valid0), .out_ready(out_ready),
        .int_out(int_out0), .invalid(invalid0), .inexact(inexact0)
    );

    float_to_int #(.ROUND_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .float_in(float_in), .out_valid(out_valid1), .out_ready(out_ready),
        .int_out(int_out1), .invalid(invalid1), .inexact(inexact1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp0_q[$];
    logic [33:0] exp1_q[$];
    int          lat_q[$];
    int          stall_lo = 0;
    int          stall_hi = -1;
    bit          rand_ready = 1'b0;

    // Directed table: operand, expected {int, invalid, inexact} truncating / nearest-even
    logic [31:0] vec_f[21];
    logic [33:0] vec_e0[21];
    logic [33:0] vec_e1[21];

    // Reference: integer quotient/remainder against 2^(23-E)
    function automatic logic [33:0] ref_conv(input logic [31:0] f, input bit rm);
        int e;
        int s;
        logic [63:0] m, q, r, half, mag;
        logic        inx;
        logic [31:0] res;
        e = int'(f[30:23]) - 127;
        m = {40'd0, (f[30:23] != 8'd0), f[22:0]};
        if (f[30:23] == 8'hFF && f[22:0] != 23'd0) return {32'h8000_0000, 2'b10};
        if (e >= 31) begin
            if (f == 32'hCF00_0000) return {32'h8000_0000, 2'b00};
            return {(f[31] ? 32'h8000_0000 : 32'h7FFF_FFFF), 2'b10};
        end
        if (e >= 23) begin
            mag = m << (e - 23);
            inx = 1'b0;
        end else begin
            s = 23 - e;
            if (s > 40) s = 40;
            q = m >> s;
            r = m - (q << s);
            half = 64'd1 << (s - 1);
            inx = (r != 64'd0);
            mag = q;
            if (rm && (r > half || (r == half && q[0]))) mag = q + 64'd1;
        end
        res = f[31] ? (32'd0 - mag[31:0]) : mag[31:0];
        return {res, 1'b0, inx};
    endfunction

    // out_ready driver: stall window or random backpressure
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
        end
    end

    // Monitor / scoreboard
    initial begin : monitor
        logic [34:0] prev0, prev1;
        logic [33:0] e;
        int          lat;
        bit          prev_stall;
        prev_stall = 1'b0;
        prev0 = '0;
        prev1 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall) begin
                checks++;
                if ({out_valid0, int_out0, invalid0, inexact0} !== prev0 ||
                    {out_valid1, int_out1, invalid1, inexact1} !== prev1) begin
                    errors++;
                    $display("FAIL stall_hold: got %h/%h expected %h/%h",
                             {out_valid0, int_out0, invalid0, inexact0},
                             {out_valid1, int_out1, invalid1, inexact1}, prev0, prev1);
                end
            end
            checks++;
            if (in_ready0 !== !(out_valid0 && !out_ready) || in_ready1 !== in_ready0) begin
                errors++;
                $display("FAIL in_ready: got %b/%b expected %b", in_ready0, in_ready1,
                         !(out_valid0 && !out_ready));
            end
            if (out_valid0 && out_ready) begin
                checks++;
                if (exp0_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out dut0: got %h expected none", int_out0);
                end else begin
                    e = exp0_q.pop_front();
                    lat = lat_q.pop_front();
                    if ({int_out0, invalid0, inexact0} !== e) begin
                        errors++;
                        $display("FAIL result dut0: got %h inv=%b inx=%b expected %h inv=%b inx=%b",
                                 int_out0, invalid0, inexact0, e[33:2], e[1], e[0]);
                    end
                    if (lat >= 0) begin
                        checks++;
                        if (cyc != lat) begin
                            errors++;
                            $display("FAIL latency: got cycle %0d expected cycle %0d", cyc, lat);
                        end
                    end
                end
            end
            if (out_valid1 && out_ready) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_out dut1: got %h expected none", int_out1);
                end else begin
                    e = exp1_q.pop_front();
                    if ({int_out1, invalid1, inexact1} !== e) begin
                        errors++;
                        $display("FAIL result dut1: got %h inv=%b inx=%b expected %h inv=%b inx=%b",
                                 int_out1, invalid1, inexact1, e[33:2], e[1], e[0]);
                    end
                end
            end
            prev_stall = out_valid0 && !out_ready;
            prev0 = {out_valid0, int_out0, invalid0, inexact0};
            prev1 = {out_valid1, int_out1, invalid1, inexact1};
        end
    end

    task automatic send(input logic [31:0] f, input logic [33:0] e0, input logic [33:0] e1,
                        input bit chk_lat);
        int waited;
        bit ok;
        waited = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        float_in = f;
        while (!ok) begin
            @(negedge clk);
            if (in_ready0) begin
                ok = 1'b1;
            end else begin
                waited++;
                if (waited > 100) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected 1", waited);
                    break;
                end
            end
        end
        if (ok) begin
            exp0_q.push_back(e0);
            exp1_q.push_back(e1);
            lat_q.push_back(chk_lat ? cyc + 3 : -1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && waited < 300) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d pending expected 0", exp0_q.size(), exp1_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_f  = '{32'h3F80_0000, 32'hC020_0000, 32'h4060_0000, 32'h4020_0000, 32'h3F00_0000,
                   32'h3F40_0000, 32'h3FC0_0000, 32'hBFC0_0000, 32'h3F00_0001, 32'h3EFF_FFFF,
                   32'h4B00_0001, 32'hCEFF_FFFF, 32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001,
                   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001, 32'h8000_0000,
                   32'h4228_0000};
        vec_e0 = '{{32'd1, 2'b00}, {32'hFFFF_FFFE, 2'b01}, {32'd3, 2'b01}, {32'd2, 2'b01},
                   {32'd0, 2'b01}, {32'd0, 2'b01}, {32'd1, 2'b01}, {32'hFFFF_FFFF, 2'b01},
                   {32'd0, 2'b01}, {32'd0, 2'b01}, {32'h0080_0001, 2'b00}, {32'h8000_0080, 2'b00},
                   {32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b00}, {32'h8000_0000, 2'b10},
                   {32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b10}, {32'h8000_0000, 2'b10},
                   {32'd0, 2'b01}, {32'd0, 2'b00}, {32'd42, 2'b00}};
        vec_e1 = '{{32'd1, 2'b00}, {32'hFFFF_FFFE, 2'b01}, {32'd4, 2'b01}, {32'd2, 2'b01},
                   {32'd0, 2'b01}, {32'd1, 2'b01}, {32'd2, 2'b01}, {32'hFFFF_FFFE, 2'b01},
                   {32'd1, 2'b01}, {32'd0, 2'b01}, {32'h0080_0001, 2'b00}, {32'h8000_0080, 2'b00},
                   {32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b00}, {32'h8000_0000, 2'b10},
                   {32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b10}, {32'h8000_0000, 2'b10},
                   {32'd0, 2'b01}, {32'd0, 2'b00}, {32'd42, 2'b00}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid0, int_out0, invalid0, inexact0, in_ready0} !== {1'b0, 32'd0, 3'b001} ||
            {out_valid1, int_out1, invalid1, inexact1, in_ready1} !== {1'b0, 32'd0, 3'b001}) begin
            errors++;
            $display("FAIL reset_state: got %h/%h expected %h",
                     {out_valid0, int_out0, invalid0, inexact0, in_ready0},
                     {out_valid1, int_out1, invalid1, inexact1, in_ready1}, {1'b0, 32'd0, 3'b001});
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single operands with latency check
        for (int i = 0; i < 21; i++) begin
            send(vec_f[i], vec_e0[i], vec_e1[i], 1'b1);
            repeat (4) @(posedge clk);
            #1;
        end
        drain();

        // Back-to-back stream with a stall window
        stall_lo = cyc + 5;
        stall_hi = cyc + 7;
        for (int i = 0; i < 8; i++) send(vec_f[i], vec_e0[i], vec_e1[i], 1'b0);
        drain();
        stall_lo = 0;
        stall_hi = -1;

        // Reset with three operands in flight
        for (int i = 10; i < 13; i++) send(vec_f[i], vec_e0[i], vec_e1[i], 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: got out_valid %b/%b expected 0", out_valid0, out_valid1);
        end
        exp0_q.delete();
        exp1_q.delete();
        lat_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        send(32'h4228_0000, {32'd42, 2'b00}, {32'd42, 2'b00}, 1'b1);
        drain();

        // Random sweep with random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] f;
            f = $urandom;
            if ($urandom_range(0, 9) < 7) f[30:23] = 8'($urandom_range(110, 160));
            send(f, ref_conv(f, 1'b0), ref_conv(f, 1'b1), 1'b0);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
